// File: rtl/rcvdata.sv
// ============================================================================
// rcvdata - serial receive stage (8N1, or 8E1 with RX_PARITY_EN defined)
//
// Recovers bytes from the serial line driven by the transmit path and hands
// each one to the music/command logic with a single-cycle valid strobe.
// The baud rate is picked at run time with the same 2-bit choose code the
// transmitter uses, so both ends agree on the bit period.
//
// Optional feature macro: RX_PARITY_EN
//   undefined : 8N1 frames, no parity_err port
//   defined   : 8E1 frames, a parity bit follows the data bits and
//               parity_err pulses together with rx_done on a mismatch
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   rx_in      in   1  asynchronous serial line, idles high
//   choose     in   2  baud select, 00..11 -> BAUD0..BAUD3
//   rx_data    out  8  last correctly framed byte
//   rx_done    out  1  one-cycle pulse, rx_data has just been updated
//   rx_busy    out  1  high while a frame is being received
//   frame_err  out  1  one-cycle pulse, stop bit was sampled low
//   parity_err out  1  (RX_PARITY_EN only) one-cycle pulse with rx_done
// ============================================================================
module rcvdata #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD0    = 9600,
    parameter int BAUD1    = 19200,
    parameter int BAUD2    = 38400,
    parameter int BAUD3    = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [1:0] choose,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
`ifdef RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    // Bit periods in clock cycles, truncated toward zero.
    localparam logic [15:0] BP0 = 16'(CLK_FREQ / BAUD0);
    localparam logic [15:0] BP1 = 16'(CLK_FREQ / BAUD1);
    localparam logic [15:0] BP2 = 16'(CLK_FREQ / BAUD2);
    localparam logic [15:0] BP3 = 16'(CLK_FREQ / BAUD3);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        sync3_q, sync3_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] bp_q, bp_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
`ifdef RX_PARITY_EN
    logic        par_q, par_d;
    logic        perr_q, perr_d;
`endif

    logic [15:0] bp_sel;
    logic [15:0] half_bp;
    logic        rx_s;
    logic        fall;

    // sync2_q is the synchronised line; sync3_q is one cycle older and is
    // only used to spot the start-bit falling edge.
    assign rx_s    = sync2_q;
    assign fall    = sync3_q & ~sync2_q;
    assign half_bp = bp_q >> 1;

    // Baud select decode; only looked at when a start edge is seen, so a
    // change of choose mid-frame leaves the running frame alone.
    always_comb begin
        case (choose)
            2'b00:   bp_sel = BP0;
            2'b01:   bp_sel = BP1;
            2'b10:   bp_sel = BP2;
            default: bp_sel = BP3;
        endcase
    end

    // Next-state and output logic for the receive FSM.  Strobes default to
    // zero so every pulse lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        sync1_d = rx_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        cnt_d   = cnt_q;
        bp_d    = bp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fall) begin
                    bp_d    = bp_sel;
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line in the middle of the start bit so that a
                // short low glitch is rejected as a false start.
                if (cnt_q == half_bp - 16'd1) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                // Sampling point is now mid-bit; step one full period per bit.
                if (cnt_q == bp_q - 16'd1) begin
                    cnt_d   = 16'd0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (cnt_q == bp_q - 16'd1) begin
                    cnt_d   = 16'd0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == bp_q - 16'd1) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
`ifdef RX_PARITY_EN
                        perr_d  = ^{shift_q, par_q};
`endif
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            BREAK: begin
                // Line held low past the stop bit: wait for it to return high
                // before looking for another start edge.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.  The synchroniser resets to the idle-high line level so
    // no phantom start edge appears when reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            cnt_q   <= 16'd0;
            bp_q    <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            cnt_q   <= cnt_d;
            bp_q    <= bp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);
`ifdef RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_rcvdata.sv
// ============================================================================
// tb_rcvdata - self-checking bench for rcvdata
//
// The receiver runs with a scaled-down CLK_FREQ so that every baud setting
// fits in a short run; bit periods are 260/130/65/21 cycles.  A line driver
// serialises frames, a monitor counts output pulses, and an expected-result
// model derives the outcome of each frame from its stop bit and data.
// Works with and without RX_PARITY_EN.
// ============================================================================
module tb_rcvdata;

    localparam int TB_CLK = 2500000;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [1:0] choose;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
`ifdef RX_PARITY_EN
    logic       parity_err;
`endif

    rcvdata #(
        .CLK_FREQ (TB_CLK),
        .BAUD0    (9600),
        .BAUD1    (19200),
        .BAUD2    (38400),
        .BAUD3    (115200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .choose    (choose),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
`ifdef RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Pulse monitor, sampling on the falling edge.
    int         done_cnt  = 0;
    int         ferr_cnt  = 0;
    int         bad_pulse = 0;
    int         done_cyc  = 0;
    logic [7:0] done_data = 8'h00;
    logic       perr_at_done = 1'b0;
    int         start_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_done) begin
                done_cnt  <= done_cnt + 1;
                done_cyc  <= cyc;
                done_data <= rx_data;
`ifdef RX_PARITY_EN
                perr_at_done <= parity_err;
`endif
            end
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (rx_done && frame_err) bad_pulse <= bad_pulse + 1;
`ifdef RX_PARITY_EN
            if (parity_err && !rx_done) bad_pulse <= bad_pulse + 1;
`endif
        end
    end

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
        logic       pbit;
        int         stop_low_bits;
        int         gap_bits;
        logic       exp_done;
        logic       exp_ferr;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[5];

    function automatic int bp_of(input logic [1:0] ch);
        case (ch)
            2'd0:    return TB_CLK / 9600;
            2'd1:    return TB_CLK / 19200;
            2'd2:    return TB_CLK / 38400;
            default: return TB_CLK / 115200;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Serialise one frame.  stop_low > 0 holds the stop bit low for that
    // many cycles before releasing the line.  scramble moves choose around
    // mid-frame to show the latched bit period is used.
    task automatic sendFrame(input logic [7:0] d, input int bp, input int stop_low,
                             input logic pbit, input bit scramble);
        rx_in = 1'b0;
        start_cyc = cyc;
        waitCycles(bp);
        if (scramble) choose = 2'($urandom_range(0, 3));
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            waitCycles(bp);
        end
`ifdef RX_PARITY_EN
        rx_in = pbit;
        waitCycles(bp);
`endif
        if (stop_low > 0) begin
            rx_in = 1'b0;
            waitCycles(stop_low);
            rx_in = 1'b1;
        end else begin
            rx_in = 1'b1;
            waitCycles(bp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit scramble,
                                 output int done0, output int ferr0);
        int bp;
        bp = bp_of(v.ch);
        choose = v.ch;
        done0 = done_cnt;
        ferr0 = ferr_cnt;
        sendFrame(v.data, bp, v.stop_low_bits * bp, v.pbit, scramble);
    endtask

    task automatic checkOutput(input string name, input vec_t v, input int done0, input int ferr0);
        int bp;
        int lat;
        int exp_lat;
        bp = bp_of(v.ch);
        check({name, " done pulses"}, done_cnt - done0, {31'd0, v.exp_done});
        check({name, " frame_err pulses"}, ferr_cnt - ferr0, {31'd0, v.exp_ferr});
        check({name, " rx_data"}, {24'd0, rx_data}, {24'd0, v.exp_data});
        if (v.exp_done) begin
            exp_lat = 3 + bp / 2 + 9 * bp;
`ifdef RX_PARITY_EN
            exp_lat = exp_lat + bp;
            check({name, " parity_err"}, {31'd0, perr_at_done}, {31'd0, v.exp_perr});
`endif
            check({name, " data at done"}, {24'd0, done_data}, {24'd0, v.exp_data});
            lat = done_cyc - start_cyc;
            checks++;
            if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
                errors++;
                $display("[TB] FAIL %s latency: got %0d expected %0d +/-1", name, lat, exp_lat);
            end
        end
    endtask

    initial begin
        int d0;
        int f0;
        int bp;
        int gap;
        vec_t v;
        logic [7:0] model_data;

        vecs[0] = '{2'd3, 8'hA5, 1'b0, 0, 2, 1'b1, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{2'd0, 8'h3C, 1'b0, 0, 0, 1'b1, 1'b0, 8'h3C, 1'b0};
        vecs[2] = '{2'd0, 8'hC3, 1'b0, 0, 2, 1'b1, 1'b0, 8'hC3, 1'b0};
        vecs[3] = '{2'd2, 8'h55, 1'b0, 3, 2, 1'b0, 1'b1, 8'hC3, 1'b0};
        vecs[4] = '{2'd2, 8'h12, 1'b0, 0, 2, 1'b1, 1'b0, 8'h12, 1'b0};

        rst    = 1'b1;
        rx_in  = 1'b1;
        choose = 2'd0;
        waitCycles(3);
        check("reset rx_data", {24'd0, rx_data}, 32'h0);
        check("reset rx_done", {31'd0, rx_done}, 32'h0);
        check("reset rx_busy", {31'd0, rx_busy}, 32'h0);
        check("reset frame_err", {31'd0, frame_err}, 32'h0);
        rst = 1'b0;
        waitCycles(10);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], 1'b0, d0, f0);
            checkOutput($sformatf("vec%0d", i), vecs[i], d0, f0);
            bp = bp_of(vecs[i].ch);
            if (vecs[i].gap_bits > 0) begin
                waitCycles(vecs[i].gap_bits * bp);
                check($sformatf("vec%0d idle busy", i), {31'd0, rx_busy}, 32'h0);
            end
        end
        model_data = 8'h12;

        // Short low glitch: rejected at the mid-start-bit check.
        choose = 2'd3;
        bp = bp_of(2'd3);
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx_in = 1'b0;
        waitCycles(bp / 2 - 4);
        rx_in = 1'b1;
        waitCycles(2 * bp);
        check("glitch busy", {31'd0, rx_busy}, 32'h0);
        check("glitch no done", done_cnt - d0, 32'h0);
        check("glitch no frame_err", ferr_cnt - f0, 32'h0);
        check("glitch rx_data", {24'd0, rx_data}, {24'd0, model_data});

        // Reset in the middle of data bit 4 of 8'hFF.
        choose = 2'd1;
        bp = bp_of(2'd1);
        d0 = done_cnt;
        rx_in = 1'b0;
        waitCycles(bp);
        rx_in = 1'b1;
        waitCycles(4 * bp + bp / 2);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        check("midreset rx_data", {24'd0, rx_data}, 32'h0);
        check("midreset rx_done", {31'd0, rx_done}, 32'h0);
        check("midreset rx_busy", {31'd0, rx_busy}, 32'h0);
        check("midreset frame_err", {31'd0, frame_err}, 32'h0);
        waitCycles(5 * bp);
        check("midreset no done", done_cnt - d0, 32'h0);
        model_data = 8'h00;
        v = '{2'd1, 8'h81, 1'b0, 0, 1, 1'b1, 1'b0, 8'h81, 1'b0};
        applyStimulus(v, 1'b0, d0, f0);
        checkOutput("after reset 81", v, d0, f0);
        waitCycles(bp);
        model_data = 8'h81;

`ifdef RX_PARITY_EN
        v = '{2'd3, 8'h07, 1'b1, 0, 2, 1'b1, 1'b0, 8'h07, 1'b0};
        applyStimulus(v, 1'b0, d0, f0);
        checkOutput("parity good", v, d0, f0);
        waitCycles(2 * bp_of(2'd3));
        v = '{2'd3, 8'h07, 1'b0, 0, 2, 1'b1, 1'b0, 8'h07, 1'b1};
        applyStimulus(v, 1'b0, d0, f0);
        checkOutput("parity bad", v, d0, f0);
        waitCycles(2 * bp_of(2'd3));
        model_data = 8'h07;
`endif

        // Random frames against the expected-result model: a high stop bit
        // delivers the byte, a low one flags a frame error and keeps the
        // previous byte; parity_err is the XOR of data and parity bit.
        for (int n = 0; n < 24; n++) begin
            v.ch   = 2'($urandom_range(0, 3));
            v.data = 8'($urandom);
            v.pbit = 1'($urandom);
            v.stop_low_bits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            v.exp_done = (v.stop_low_bits == 0);
            v.exp_ferr = !v.exp_done;
            if (v.exp_done) model_data = v.data;
            v.exp_data = model_data;
            v.exp_perr = ^{v.data, v.pbit};
            bp = bp_of(v.ch);
            gap = v.exp_done ? int'($urandom_range(0, bp / 2)) : int'($urandom_range(5, bp));
            v.gap_bits = 0;
            applyStimulus(v, 1'b1, d0, f0);
            checkOutput($sformatf("rand%0d", n), v, d0, f0);
            choose = v.ch;
            waitCycles(gap);
            if (gap >= 5) check($sformatf("rand%0d idle busy", n), {31'd0, rx_busy}, 32'h0);
        end

        waitCycles(20);
        check("done/err overlap", bad_pulse, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
